// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired CPU controller: states, opcodes, ALU codes.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  // One state per microstep; RESET and HALT are the only idle states.
  typedef enum logic [3:0] {
    RESET = 4'd0,
    T0    = 4'd1,
    T1    = 4'd2,
    T2    = 4'd3,
    T3    = 4'd4,
    T4    = 4'd5,
    T5    = 4'd6,
    T6    = 4'd7,
    T7    = 4'd8,
    HALT  = 4'd9
  } state_t;

  // Opcodes, taken from IR[31:27].
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes driven while Z is being loaded.
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_INC  = 5'b11111;

  // Full datapath control word for one microstep.
  typedef struct packed {
    logic       HiIn;
    logic       LoIn;
    logic       ZIn;
    logic       PCIn;
    logic       MDRIn;
    logic       MARIn;
    logic       YIn;
    logic       OPortIn;
    logic       IRIn;
    logic       HiOut;
    logic       LoOut;
    logic       ZHiOut;
    logic       ZLoOut;
    logic       PCOut;
    logic       MDROut;
    logic       IPortOut;
    logic       COut;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       RIn;
    logic       ROut;
    logic       BAOut;
    logic       Conin;
    logic       memread;
    logic       memwrite;
    logic [4:0] ALUCode;
  } ctrl_sig_t;

  function automatic logic is_rtype(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_itype(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [4:0] itype_alu(input logic [4:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Last microstep of each instruction; nop, halt and unknown opcodes end at fetch.
  function automatic state_t final_step(input logic [4:0] op);
    if ((op == OP_LD) || (op == OP_ST))          return T7;
    if (op == OP_BR)                             return T6;
    if ((op == OP_LDI) || is_rtype(op) || is_itype(op)) return T5;
    return T2;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundles the controller's instruction/condition inputs and all datapath controls.
// Latency: n/a (wiring only).
// Backpressure: none; the datapath always accepts the control word.
interface control_unit_if;
  import cpu_ctrl_pkg::*;

  logic [31:0] IR;
  logic        ConOut;
  logic        stop;
  logic        run;

  logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
  logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
  logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin;
  logic memread, memwrite;
  logic [4:0] ALUCode;

  // Controller side.
  modport master (
    input  IR, ConOut, stop,
    output run,
    output HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
    output HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
    output Gra, Grb, Grc, RIn, ROut, BAOut, Conin,
    output memread, memwrite, ALUCode
  );

  // Datapath side.
  modport slave (
    output IR, ConOut, stop,
    input  run,
    input  HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
    input  HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
    input  Gra, Grb, Grc, RIn, ROut, BAOut, Conin,
    input  memread, memwrite, ALUCode
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, opcode, ConOut) into the datapath control word.
// Latency: zero cycles, purely combinational.
// Backpressure: none.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       ConOut,
  output ctrl_sig_t  sig,
  output logic       run
);

  logic is_ld, is_ldi, is_st, is_br, is_r, is_i, is_mem_addr;

  assign is_ld       = (opcode == OP_LD);
  assign is_ldi      = (opcode == OP_LDI);
  assign is_st       = (opcode == OP_ST);
  assign is_br       = (opcode == OP_BR);
  assign is_r        = is_rtype(opcode);
  assign is_i        = is_itype(opcode);
  // ld, ldi and st share the effective-address computation in T3/T4.
  assign is_mem_addr = is_ld || is_ldi || is_st;

  // Per-step control word; anything not named for a step stays 0.
  always_comb begin
    sig = '0;
    run = (state != RESET) && (state != HALT);
    case (state)
      T0: begin
        sig.PCOut   = 1'b1;
        sig.MARIn   = 1'b1;
        sig.ZIn     = 1'b1;
        sig.ALUCode = ALU_INC;
      end
      T1: begin
        sig.ZLoOut  = 1'b1;
        sig.PCIn    = 1'b1;
        sig.memread = 1'b1;
        sig.MDRIn   = 1'b1;
      end
      T2: begin
        sig.MDROut = 1'b1;
        sig.IRIn   = 1'b1;
      end
      T3: begin
        if (is_mem_addr) begin
          sig.Grb   = 1'b1;
          sig.BAOut = 1'b1;
          sig.YIn   = 1'b1;
        end else if (is_r || is_i) begin
          sig.Grb  = 1'b1;
          sig.ROut = 1'b1;
          sig.YIn  = 1'b1;
        end else if (is_br) begin
          sig.Gra   = 1'b1;
          sig.ROut  = 1'b1;
          sig.Conin = 1'b1;
        end
      end
      T4: begin
        if (is_mem_addr) begin
          sig.COut    = 1'b1;
          sig.ZIn     = 1'b1;
          sig.ALUCode = ALU_ADD;
        end else if (is_r) begin
          sig.Grc     = 1'b1;
          sig.ROut    = 1'b1;
          sig.ZIn     = 1'b1;
          sig.ALUCode = opcode;
        end else if (is_i) begin
          sig.COut    = 1'b1;
          sig.ZIn     = 1'b1;
          sig.ALUCode = itype_alu(opcode);
        end else if (is_br) begin
          sig.PCOut = 1'b1;
          sig.YIn   = 1'b1;
        end
      end
      T5: begin
        if (is_ld || is_st) begin
          sig.ZLoOut = 1'b1;
          sig.MARIn  = 1'b1;
        end else if (is_ldi || is_r || is_i) begin
          sig.ZLoOut = 1'b1;
          sig.Gra    = 1'b1;
          sig.RIn    = 1'b1;
        end else if (is_br) begin
          sig.COut    = 1'b1;
          sig.ZIn     = 1'b1;
          sig.ALUCode = ALU_ADD;
        end
      end
      T6: begin
        if (is_ld) begin
          sig.memread = 1'b1;
          sig.MDRIn   = 1'b1;
        end else if (is_st) begin
          sig.Gra   = 1'b1;
          sig.ROut  = 1'b1;
          sig.MDRIn = 1'b1;
        end else if (is_br) begin
          // Branch target only lands in PC when the condition held.
          sig.ZLoOut = ConOut;
          sig.PCIn   = ConOut;
        end
      end
      T7: begin
        if (is_ld) begin
          sig.MDROut = 1'b1;
          sig.Gra    = 1'b1;
          sig.RIn    = 1'b1;
        end else if (is_st) begin
          sig.memwrite = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore controller sequencing fetch and execute microsteps T0..T7.
// Latency: one state per clock; instructions take 3 to 8 cycles.
// Backpressure: none; stop is honoured only at an instruction's final step.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master cu
);

  state_t     state;
  state_t     state_nxt;
  state_t     done_nxt;
  ctrl_sig_t  sig;
  logic [4:0] opcode;
  logic       at_final;
  logic       unused_ir;

  assign opcode    = cu.IR[31:27];
  assign unused_ir = ^cu.IR[26:0];
  assign at_final  = (state == final_step(opcode));
  assign done_nxt  = cu.stop ? HALT : T0;

  // State register; clear wins over everything, including a pending memwrite step.
  always_ff @(posedge clock) begin
    if (clear) state <= RESET;
    else       state <= state_nxt;
  end

  // Next-state: walk the steps, leaving at the opcode's final step.
  always_comb begin
    state_nxt = state;
    case (state)
      RESET: state_nxt = T0;
      T0:    state_nxt = T1;
      T1:    state_nxt = T2;
      T2: begin
        if (opcode == OP_HALT) state_nxt = HALT;
        else if (at_final)     state_nxt = done_nxt;
        else                   state_nxt = T3;
      end
      T3:    state_nxt = at_final ? done_nxt : T4;
      T4:    state_nxt = at_final ? done_nxt : T5;
      T5:    state_nxt = at_final ? done_nxt : T6;
      T6:    state_nxt = at_final ? done_nxt : T7;
      T7:    state_nxt = done_nxt;
      HALT:  state_nxt = HALT;
      default: state_nxt = RESET;
    endcase
  end

  ctrl_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .ConOut (cu.ConOut),
    .sig    (sig),
    .run    (cu.run)
  );

  assign cu.HiIn     = sig.HiIn;
  assign cu.LoIn     = sig.LoIn;
  assign cu.ZIn      = sig.ZIn;
  assign cu.PCIn     = sig.PCIn;
  assign cu.MDRIn    = sig.MDRIn;
  assign cu.MARIn    = sig.MARIn;
  assign cu.YIn      = sig.YIn;
  assign cu.OPortIn  = sig.OPortIn;
  assign cu.IRIn     = sig.IRIn;
  assign cu.HiOut    = sig.HiOut;
  assign cu.LoOut    = sig.LoOut;
  assign cu.ZHiOut   = sig.ZHiOut;
  assign cu.ZLoOut   = sig.ZLoOut;
  assign cu.PCOut    = sig.PCOut;
  assign cu.MDROut   = sig.MDROut;
  assign cu.IPortOut = sig.IPortOut;
  assign cu.COut     = sig.COut;
  assign cu.Gra      = sig.Gra;
  assign cu.Grb      = sig.Grb;
  assign cu.Grc      = sig.Grc;
  assign cu.RIn      = sig.RIn;
  assign cu.ROut     = sig.ROut;
  assign cu.BAOut    = sig.BAOut;
  assign cu.Conin    = sig.Conin;
  assign cu.memread  = sig.memread;
  assign cu.memwrite = sig.memwrite;
  assign cu.ALUCode  = sig.ALUCode;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: directed scenarios plus random instruction streams vs a step-table model.
// Latency: n/a.
// Backpressure: n/a.
module tb_control_unit;

  logic clock;
  logic clear;
  control_unit_if bus ();

  control_unit dut (
    .clock (clock),
    .clear (clear),
    .cu    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: -1 RESET, 0..7 step Tn, 8 HALT.
  int  m_st  = -1;
  bit  known = 0;
  int  cyc   = 0;
  int  t0_cycles[$];
  bit  mw_seen;
  logic t6_pcin, t6_zlo, t5_rin;

  logic [4:0] valid_ops [13] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                 5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110,
                                 5'b10010, 5'b11010, 5'b11011};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit position of each named control in the bench's own mask layout.
  function automatic int name_idx(input string t);
    case (t)
      "HiIn": return 0;     "LoIn": return 1;    "ZIn": return 2;     "PCIn": return 3;
      "MDRIn": return 4;    "MARIn": return 5;   "YIn": return 6;     "OPortIn": return 7;
      "IRIn": return 8;     "HiOut": return 9;   "LoOut": return 10;  "ZHiOut": return 11;
      "ZLoOut": return 12;  "PCOut": return 13;  "MDROut": return 14; "IPortOut": return 15;
      "COut": return 16;    "Gra": return 17;    "Grb": return 18;    "Grc": return 19;
      "RIn": return 20;     "ROut": return 21;   "BAOut": return 22;  "Conin": return 23;
      "memread": return 24; "memwrite": return 25;
      default: return -1;
    endcase
  endfunction

  function automatic logic [25:0] to_mask(input string s);
    logic [25:0] m;
    string tok;
    int idx;
    m = '0;
    tok = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == " ") begin
        if (tok.len() > 0) begin
          idx = name_idx(tok);
          if (idx >= 0) m[idx] = 1'b1;
        end
        tok = "";
      end else begin
        tok = {tok, s.substr(i, i)};
      end
    end
    return m;
  endfunction

  function automatic logic [25:0] obs_mask();
    logic [25:0] m;
    m[0] = bus.HiIn;    m[1] = bus.LoIn;    m[2] = bus.ZIn;      m[3] = bus.PCIn;
    m[4] = bus.MDRIn;   m[5] = bus.MARIn;   m[6] = bus.YIn;      m[7] = bus.OPortIn;
    m[8] = bus.IRIn;    m[9] = bus.HiOut;   m[10] = bus.LoOut;   m[11] = bus.ZHiOut;
    m[12] = bus.ZLoOut; m[13] = bus.PCOut;  m[14] = bus.MDROut;  m[15] = bus.IPortOut;
    m[16] = bus.COut;   m[17] = bus.Gra;    m[18] = bus.Grb;     m[19] = bus.Grc;
    m[20] = bus.RIn;    m[21] = bus.ROut;   m[22] = bus.BAOut;   m[23] = bus.Conin;
    m[24] = bus.memread; m[25] = bus.memwrite;
    return m;
  endfunction

  // Instruction class: 0 ld, 1 ldi, 2 st, 3 reg ALU, 4 imm ALU, 5 br, 6 halt, 7 other.
  function automatic int cls(input logic [4:0] op);
    case (op)
      5'b00000: return 0;
      5'b00001: return 1;
      5'b00010: return 2;
      5'b00011, 5'b00100, 5'b00101, 5'b00110: return 3;
      5'b01100, 5'b01101, 5'b01110: return 4;
      5'b10010: return 5;
      5'b11011: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic int last_step(input logic [4:0] op);
    case (cls(op))
      0, 2: return 7;
      1, 3, 4: return 5;
      5: return 6;
      default: return 2;
    endcase
  endfunction

  // Expected asserted controls, written straight from the per-instruction step lists.
  function automatic string exp_names(input int st, input logic [4:0] op, input logic con);
    int c;
    c = cls(op);
    case (st)
      0: return "PCOut MARIn ZIn";
      1: return "ZLoOut PCIn memread MDRIn";
      2: return "MDROut IRIn";
      3: if (c <= 2) return "Grb BAOut YIn";
         else if (c == 3 || c == 4) return "Grb ROut YIn";
         else if (c == 5) return "Gra ROut Conin";
      4: if (c <= 2 || c == 4) return "COut ZIn";
         else if (c == 3) return "Grc ROut ZIn";
         else if (c == 5) return "PCOut YIn";
      5: if (c == 0 || c == 2) return "ZLoOut MARIn";
         else if (c == 1 || c == 3 || c == 4) return "ZLoOut Gra RIn";
         else if (c == 5) return "COut ZIn";
      6: if (c == 0) return "memread MDRIn";
         else if (c == 2) return "Gra ROut MDRIn";
         else if (c == 5) return con ? "ZLoOut PCIn" : "";
      7: if (c == 0) return "MDROut Gra RIn";
         else if (c == 2) return "memwrite";
      default: return "";
    endcase
    return "";
  endfunction

  function automatic logic [4:0] exp_alu(input int st, input logic [4:0] op);
    int c;
    c = cls(op);
    if (st == 0) return 5'b11111;
    if (st == 4 && c <= 2) return 5'b00011;
    if (st == 4 && c == 3) return op;
    if (st == 4 && c == 4) return (op == 5'b01101) ? 5'b00101 : (op == 5'b01110) ? 5'b00110 : 5'b00011;
    if (st == 5 && c == 5) return 5'b00011;
    return 5'b00000;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit clr, input bit stp, input bit con);
    logic [4:0] op;
    clear = clr;
    bus.stop = stp;
    bus.ConOut = con;
    #1;
    op = bus.IR[31:27];
    if (known) begin
      chk($sformatf("sigs st%0d op%b", m_st, op), {6'd0, obs_mask()}, {6'd0, to_mask(exp_names(m_st, op, con))});
      chk($sformatf("alu st%0d op%b", m_st, op), {27'd0, bus.ALUCode}, {27'd0, exp_alu(m_st, op)});
      chk($sformatf("run st%0d", m_st), {31'd0, bus.run}, {31'd0, (m_st >= 0 && m_st <= 7)});
    end
    if (bus.memwrite === 1'b1) mw_seen = 1;
    if (bus.PCOut === 1'b1 && bus.MARIn === 1'b1) t0_cycles.push_back(cyc);
    if (known && m_st == 6) begin
      t6_pcin = bus.PCIn;
      t6_zlo  = bus.ZLoOut;
    end
    if (known && m_st == 5) t5_rin = bus.RIn;
    @(posedge clock);
    if (clr) begin
      m_st = -1;
      known = 1;
    end else if (m_st == -1) m_st = 0;
    else if (m_st == 8) m_st = 8;
    else if (m_st == 2 && cls(op) == 6) m_st = 8;
    else if (m_st == last_step(op)) m_st = stp ? 8 : 0;
    else m_st = m_st + 1;
    cyc++;
    @(negedge clock);
  endtask

  task automatic set_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom();
    bus.IR = {op, r[26:0]};
  endtask

  initial begin
    clear = 1'b1;
    bus.IR = '0;
    bus.ConOut = 1'b0;
    bus.stop = 1'b0;
    @(negedge clock);

    // ld R2: full eight-step instruction, T0 recurs eight cycles later.
    bus.IR = 32'h0100_0078;
    step(1, 0, 0);
    t0_cycles.delete();
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    if (t0_cycles.size() >= 2) chk("ld_t0_period", t0_cycles[1] - t0_cycles[0], 8);
    else chk("ld_t0_seen", t0_cycles.size(), 2);

    // add: ALU code only in T4, back to T0 after T5.
    bus.IR = 32'h1800_0000;
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    chk("add_back_to_t0", m_st, 1);

    // br with condition false, then true.
    set_ir(5'b10010);
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    chk("br_con0_pcin", {31'd0, t6_pcin}, 0);
    chk("br_con0_zlo", {31'd0, t6_zlo}, 0);
    step(1, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    chk("br_con1_pcin", {31'd0, t6_pcin}, 1);
    chk("br_con1_zlo", {31'd0, t6_zlo}, 1);

    // halt: parks after T2, silent for 10 cycles, clear restarts.
    set_ir(5'b11011);
    step(1, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 0);
    chk("halt_run", {31'd0, bus.run}, 0);
    chk("halt_quiet", {6'd0, obs_mask()}, 0);
    set_ir(5'b11010);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("halt_restart_t0", m_st, 1);

    // st interrupted by clear in T6: memwrite must never appear.
    set_ir(5'b00010);
    step(1, 0, 0);
    mw_seen = 0;
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("st_clear_no_memwrite", {31'd0, mw_seen}, 0);

    // ldi with stop held from T3: finishes the write-back, then halts.
    set_ir(5'b00001);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    t5_rin = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    chk("ldi_stop_rin", {31'd0, t5_rin}, 1);
    chk("ldi_stop_halt", m_st, 8);

    // Random instruction stream with sporadic stop/clear.
    step(1, 0, 0);
    for (int i = 0; i < 800; i++) begin
      bit clr, stp;
      if (m_st == 0 || m_st == -1) begin
        if ($urandom_range(0, 6) == 0) set_ir(5'($urandom_range(0, 31)));
        else set_ir(valid_ops[$urandom_range(0, 12)]);
      end
      clr = (m_st == 8 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 99) == 0);
      stp = ($urandom_range(0, 9) == 0);
      step(clr, stp, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
